// File: rtl/biquad_cascade_engine.sv
// biquad_cascade_engine: cascade of second-order IIR sections sharing one multiplier and accumulator
module biquad_cascade_engine #(
  parameter int N = 24,
  parameter int F = 14,
  parameter int SECTIONS = 2,
  localparam int NC = 5 * SECTIONS,
  localparam int AW = $clog2(NC),
  localparam int SW = SECTIONS > 1 ? $clog2(SECTIONS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic signed [N-1:0]  sample_in,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [N-1:0]  coef_wdata,
  output logic                 busy,
  output logic                 y_valid,
  output logic signed [N-1:0]  y_out,
  output logic                 sat,
  output logic                 overrun,
  output logic                 coef_err
);
  typedef enum logic [1:0] {IDLE, MAC, WB, OUT} state_t;
  state_t state, state_nx;
  logic [2:0] term;
  logic [SW-1:0] sec;
  logic [AW-1:0] cptr;
  logic signed [N-1:0] coef [NC];
  logic signed [N-1:0] x1 [SECTIONS];
  logic signed [N-1:0] x2 [SECTIONS];
  logic signed [N-1:0] y1 [SECTIONS];
  logic signed [N-1:0] y2 [SECTIONS];
  logic signed [N-1:0] xs, opd, res;
  logic signed [2*N-1:0] prod;
  logic signed [2*N+2:0] acc, sh;
  logic ovf, sat_acc, last, accept, coef_ok, mac_en, wb_en, out_en;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state == IDLE ? (sample_valid ? MAC : IDLE) :
               state == MAC  ? (term == 3'd4 ? WB : MAC) :
               state == WB   ? (last ? OUT : MAC) : IDLE;
  end
  always_comb begin
    busy = state != IDLE;
    accept = state == IDLE && sample_valid;
    mac_en = state == MAC;
    wb_en = state == WB;
    out_en = state == OUT;
  end
  assign last = sec == SW'(SECTIONS - 1);
  assign coef_ok = !busy && coef_addr < AW'(NC);
  assign opd = term == 3'd0 ? xs : term == 3'd1 ? x1[sec] : term == 3'd2 ? x2[sec] :
               term == 3'd3 ? y1[sec] : y2[sec];
  assign prod = coef[cptr] * opd;
  assign sh = acc >>> F;
  assign ovf = !(&sh[2*N+2:N-1]) && (|sh[2*N+2:N-1]);
  assign res = ovf ? (sh[2*N+2] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}}) : sh[N-1:0];
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      term <= '0;
      sec <= '0;
      cptr <= '0;
      xs <= '0;
      sat_acc <= 1'b0;
      y_valid <= 1'b0;
      y_out <= '0;
      sat <= 1'b0;
      overrun <= 1'b0;
      coef_err <= 1'b0;
      for (int i = 0; i < NC; i++) coef[i] <= i % 5 == 0 ? N'(1 << F) : '0;
      for (int i = 0; i < SECTIONS; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
    end else begin
      y_valid <= out_en;
      if (out_en) begin
        y_out <= xs;
        sat <= sat_acc;
      end
      if (sample_valid && busy) overrun <= 1'b1;
      if (coef_we && coef_ok) coef[coef_addr] <= coef_wdata;
      if (coef_we && !coef_ok) coef_err <= 1'b1;
      if (accept) begin
        xs <= sample_in;
        sat_acc <= 1'b0;
      end
      if (mac_en) begin
        acc <= acc + (2*N+3)'(prod);
        term <= term == 3'd4 ? 3'd0 : term + 3'd1;
        cptr <= cptr + 1'b1;
      end
      if (wb_en) begin
        acc <= '0;
        x2[sec] <= x1[sec];
        x1[sec] <= xs;
        y2[sec] <= y1[sec];
        y1[sec] <= res;
        xs <= res;
        sat_acc <= sat_acc | ovf;
        sec <= last ? '0 : sec + 1'b1;
        cptr <= last ? '0 : cptr;
      end
    end
  end
endmodule

// File: doc/biquad_cascade_engine.md
BIQUAD_CASCADE_ENGINE -- requirements
Module: biquad_cascade_engine

Interface
REQ-001 Parameter N, default 24, signed two's-complement word width of samples and coefficients.
REQ-002 Parameter F, default 14, fractional bits of coefficients (1.0 = 2^F).
REQ-003 Parameter SECTIONS, default 2, number of cascaded second-order sections (1..8).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sample_valid  input  1  one-cycle strobe qualifying sample_in.
REQ-007 sample_in  input  N  signed input sample x[k].
REQ-008 coef_we  input  1  coefficient write strobe.
REQ-009 coef_addr  input  clog2(5*SECTIONS)  index = 5*s + i; i: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-010 coef_wdata  input  N  signed coefficient, F fractional bits.
REQ-011 busy  output  1  high from accept edge until y_valid edge.
REQ-012 y_valid  output  1  one-cycle strobe qualifying y_out.
REQ-013 y_out  output  N  signed cascade output, held until next y_valid.
REQ-014 sat  output  1  valid with y_valid; high if any section saturated for this sample.
REQ-015 overrun  output  1  sticky; sample_valid seen while busy.
REQ-016 coef_err  output  1  sticky; coef_we while busy or with out-of-range address.

Function
REQ-017 Each section s SHALL compute y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2; a1/a2 are stored pre-negated (no subtraction in datapath).
REQ-018 One shared N x N signed multiplier and a 2N+3-bit signed accumulator SHALL be time-multiplexed; one product accumulated per MAC cycle.
REQ-019 FSM states IDLE, MAC, WB, OUT; IDLE->MAC on sample_valid; MAC runs 5 cycles (term order b0,b1,b2,a1,a2) then WB; WB->MAC for next section, or WB->OUT after last section; OUT->IDLE.
REQ-020 In WB: result = accumulator arithmetic-shifted right by F (truncation toward -inf), saturated to [-2^(N-1), 2^(N-1)-1]; accumulator cleared.
REQ-021 In WB, section delay lines update: x2<=x1, x1<=x, y2<=y1, y1<=saturated result; saturated result becomes x of section s+1.
REQ-022 Latency: y_valid SHALL assert exactly 6*SECTIONS+1 rising edges after the accepting edge (13 for SECTIONS=2), high for one cycle in OUT.
REQ-023 sample_valid while busy SHALL be ignored (no state change to computation) and set overrun.
REQ-024 sample_valid in IDLE SHALL be accepted on that edge; back-to-back operation allowed with sample_valid asserted in the cycle after y_valid.
REQ-025 Coefficient write SHALL take effect on the edge of coef_we only when busy=0 and coef_addr < 5*SECTIONS; otherwise ignored and coef_err set.
REQ-026 Coefficient write coinciding with an accepted sample_valid (IDLE) SHALL be applied before that sample's first MAC.
REQ-027 sat SHALL be OR of saturation events over all sections of the current sample, registered with y_out.

Reset
REQ-028 On reset: state IDLE; busy, y_valid, sat, overrun, coef_err = 0; y_out = 0; accumulator and all delay lines = 0.
REQ-029 On reset: every section b0 = 2^F, all other coefficients = 0 (cascade is identity).
REQ-030 Reset mid-computation SHALL abort; no y_valid for the aborted sample; busy = 0 on the following cycle.

Verification (N=24, F=14, SECTIONS=2)
REQ-031 After reset, x=1000 -> y_out=1000, y_valid 13 edges after accept, sat=0.
REQ-032 Write addr0 (s0 b0)=8192; x=1000 -> y_out=500; x=-3 -> y_out=-2 (floor of -1.5).
REQ-033 s0 a1=8192, b0=16384; inputs 16384,0,0 each accepted after prior y_valid -> y_out 16384, 8192, 4096.
REQ-034 s0 b0=65536 (4.0); x=4000000 -> y_out=8388607, sat=1; x=-4000000 -> y_out=-8388608, sat=1.
REQ-035 sample_valid and coef_we (addr0) at accept+3 -> first result unchanged, overrun=1, coef_err=1, coefficient not written; coef_addr=10 in IDLE -> coef_err=1.
REQ-036 reset at accept+5 -> no y_valid, busy=0 next cycle; next x=1000 -> y_out=1000 (delay lines and coefficients at reset values).
